// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 encodings
// and request legality checks.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) bad = (funct3 > F3_W);
        else    bad = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load lanes, and merges
// sub-word store data into an old memory word.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] load_word,
    input  logic [WIDTH-1:0] old_word,
    input  logic [WIDTH-1:0] wdata,
    input  logic [1:0]       addr_lo,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] merged_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_lane = load_word[7:0];
            2'd1:    byte_lane = load_word[15:8];
            2'd2:    byte_lane = load_word[23:16];
            default: byte_lane = load_word[31:24];
        endcase
        half_lane = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        case (funct3)
            F3_B:    load_data = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_BU:   load_data = {{(WIDTH-8){1'b0}}, byte_lane};
            F3_H:    load_data = {{(WIDTH-16){half_lane[15]}}, half_lane};
            F3_HU:   load_data = {{(WIDTH-16){1'b0}}, half_lane};
            default: load_data = load_word;
        endcase
    end

    always_comb begin
        merged_data = old_word;
        case (funct3[1:0])
            2'b00: begin
                case (addr_lo)
                    2'd0:    merged_data[7:0]   = wdata[7:0];
                    2'd1:    merged_data[15:8]  = wdata[7:0];
                    2'd2:    merged_data[23:16] = wdata[7:0];
                    default: merged_data[31:24] = wdata[7:0];
                endcase
            end
            2'b01: begin
                if (addr_lo[1]) merged_data[31:16] = wdata[15:0];
                else            merged_data[15:0]  = wdata[15:0];
            end
            default: merged_data = wdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time against a word-addressed data memory,
// with read-modify-write for byte and halfword stores.
//
// state  | meaning
// IDLE   | ready; capture request, check funct3/alignment
// ACCESS | load read, SW write, or SB/SH read of old word
// MERGE  | SB/SH write of merged word
// RESP   | one-cycle response pulse
module lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int INDEX = 5
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             req_valid_in,
    output logic             req_ready_out,
    input  logic             req_we_in,
    input  logic [2:0]       req_funct3_in,
    input  logic [WIDTH-1:0] req_addr_in,
    input  logic [WIDTH-1:0] req_wdata_in,
    output logic             resp_valid_out,
    output logic [WIDTH-1:0] resp_rdata_out,
    output logic             resp_err_out,
    output logic             mem_we_out,
    output logic             mem_re_out,
    output logic [INDEX-1:0] mem_addr_out,
    output logic [WIDTH-1:0] mem_wdata_out,
    input  logic [WIDTH-1:0] mem_rdata_in
);

    state_t           state_q, state_d;
    logic             we_q;
    logic [2:0]       funct3_q;
    logic [INDEX+1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] merge_q;
    logic [WIDTH-1:0] rdata_q;
    logic             err_q;

    logic             accept;
    logic             load_cap;
    logic             merge_cap;
    logic             req_err;
    logic [WIDTH-1:0] load_data;
    logic [WIDTH-1:0] merged_data;

    // Only the word-index bits of the byte address reach the memory.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^req_addr_in[WIDTH-1:INDEX+2];

    assign req_err = is_illegal(req_we_in, req_funct3_in) ||
                     is_misaligned(req_funct3_in, req_addr_in[1:0]);

    assign mem_addr_out = addr_q[INDEX+1:2];

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .load_word   (mem_rdata_in),
        .old_word    (merge_q),
        .wdata       (wdata_q),
        .addr_lo     (addr_q[1:0]),
        .funct3      (funct3_q),
        .load_data   (load_data),
        .merged_data (merged_data)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        req_ready_out  = 1'b0;
        resp_valid_out = 1'b0;
        resp_rdata_out = '0;
        resp_err_out   = 1'b0;
        mem_we_out     = 1'b0;
        mem_re_out     = 1'b0;
        mem_wdata_out  = '0;
        accept         = 1'b0;
        load_cap       = 1'b0;
        merge_cap      = 1'b0;
        case (state_q)
            IDLE: begin
                // Ready is gated so it reads 0 while reset is held.
                req_ready_out = !rst_in;
                if (req_valid_in) begin
                    accept  = 1'b1;
                    state_d = req_err ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    mem_re_out = 1'b1;
                    load_cap   = 1'b1;
                    state_d    = RESP;
                end else if (funct3_q == F3_W) begin
                    mem_we_out    = 1'b1;
                    mem_wdata_out = wdata_q;
                    state_d       = RESP;
                end else begin
                    mem_re_out = 1'b1;
                    merge_cap  = 1'b1;
                    state_d    = MERGE;
                end
            end
            MERGE: begin
                mem_we_out    = 1'b1;
                mem_wdata_out = merged_data;
                state_d       = RESP;
            end
            RESP: begin
                resp_valid_out = 1'b1;
                resp_rdata_out = rdata_q;
                resp_err_out   = err_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we_in;
                funct3_q <= req_funct3_in;
                addr_q   <= req_addr_in[INDEX+1:0];
                wdata_q  <= req_wdata_in;
                err_q    <= req_err;
                rdata_q  <= '0;
            end
            if (load_cap)  rdata_q <= load_data;
            if (merge_cap) merge_q <= mem_rdata_in;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a falling-edge-write data memory model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic        mem_re;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:31];
    logic [4:0]  last_we_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int n_both   = 0;

    always #5 clk = ~clk;

    lsu #(.WIDTH(32), .INDEX(5)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_we_in      (req_we),
        .req_funct3_in  (req_funct3),
        .req_addr_in    (req_addr),
        .req_wdata_in   (req_wdata),
        .resp_valid_out (resp_valid),
        .resp_rdata_out (resp_rdata),
        .resp_err_out   (resp_err),
        .mem_we_out     (mem_we),
        .mem_re_out     (mem_re),
        .mem_addr_out   (mem_addr),
        .mem_wdata_out  (mem_wdata),
        .mem_rdata_in   (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(negedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            last_we_addr  <= mem_addr;
        end
        if (mem_we && mem_re) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic rdy, output logic [31:0] rdata,
                           output logic err, output int lat, output int nwe, output int nre);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1 rdy = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; nwe = 0; nre = 0; rdata = '0; err = 1'b0;
        for (int c = 1; c <= 8 && lat < 0; c++) begin
            @(negedge clk);
            if (mem_we) nwe++;
            if (mem_re) nre++;
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
            end
        end
    endtask

    task automatic req_expect(input string tag, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input int exp_lat, input int exp_nwe, input int exp_nre);
        logic        rdy;
        logic [31:0] rdata;
        logic        err;
        int          lat, nwe, nre;
        run_req(we, f3, addr, wdata, rdy, rdata, err, lat, nwe, nre);
        check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
        check({tag, "_lat"},   lat,   exp_lat);
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_err"},   {31'd0, err}, {31'd0, exp_err});
        check({tag, "_nwe"},   nwe,   exp_nwe);
        check({tag, "_nre"},   nre,   exp_nre);
    endtask

    logic [8:0] ready_mask;
    logic [8:0] resp_mask;

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        #1;
        check("rst_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_we, mem_re}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_addr", {27'd0, mem_addr}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // SW then LW
        req_expect("sw08", 1'b1, 3'b010, 32'h08, 32'h1234_5678, 32'h0, 1'b0, 2, 1, 0);
        check("sw08_waddr", {27'd0, last_we_addr}, 32'd2);
        check("sw08_mem", mem[2], 32'h1234_5678);
        req_expect("lw08", 1'b0, 3'b010, 32'h08, 32'h0, 32'h1234_5678, 1'b0, 2, 0, 1);

        // SB via RMW, upper wdata bits must be ignored
        req_expect("sb09", 1'b1, 3'b000, 32'h09, 32'hFFFF_FFAB, 32'h0, 1'b0, 3, 1, 1);
        check("sb09_waddr", {27'd0, last_we_addr}, 32'd2);
        req_expect("lw08b", 1'b0, 3'b010, 32'h08, 32'h0, 32'h1234_AB78, 1'b0, 2, 0, 1);

        // Sign/zero extension
        req_expect("sw80f0", 1'b1, 3'b010, 32'h08, 32'h0000_80F0, 32'h0, 1'b0, 2, 1, 0);
        req_expect("lb08",  1'b0, 3'b000, 32'h08, 32'h0, 32'hFFFF_FFF0, 1'b0, 2, 0, 1);
        req_expect("lbu08", 1'b0, 3'b100, 32'h08, 32'h0, 32'h0000_00F0, 1'b0, 2, 0, 1);
        req_expect("lh08",  1'b0, 3'b001, 32'h08, 32'h0, 32'hFFFF_80F0, 1'b0, 2, 0, 1);
        req_expect("lhu08", 1'b0, 3'b101, 32'h08, 32'h0, 32'h0000_80F0, 1'b0, 2, 0, 1);
        req_expect("lb09",  1'b0, 3'b000, 32'h09, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 0, 1);
        req_expect("sh0a", 1'b1, 3'b001, 32'h0A, 32'h1234_BEEF, 32'h0, 1'b0, 3, 1, 1);
        check("sh0a_mem", mem[2], 32'hBEEF_80F0);
        req_expect("lh0a",  1'b0, 3'b001, 32'h0A, 32'h0, 32'hFFFF_BEEF, 1'b0, 2, 0, 1);
        req_expect("lhu0a", 1'b0, 3'b101, 32'h0A, 32'h0, 32'h0000_BEEF, 1'b0, 2, 0, 1);

        // Errors: no memory activity, response one cycle after acceptance
        req_expect("lw0a_mis",  1'b0, 3'b010, 32'h0A, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        req_expect("sh03_mis",  1'b1, 3'b001, 32'h03, 32'h5555, 32'h0, 1'b1, 1, 0, 0);
        req_expect("ld011_ill", 1'b0, 3'b011, 32'h08, 32'h0, 32'h0, 1'b1, 1, 0, 0);
        req_expect("st100_ill", 1'b1, 3'b100, 32'h08, 32'h77, 32'h0, 1'b1, 1, 0, 0);
        check("err_mem", mem[2], 32'hBEEF_80F0);

        // Reset in the MERGE cycle of an SH
        req_expect("sw10", 1'b1, 3'b010, 32'h10, 32'hAAAA_AAAA, 32'h0, 1'b0, 2, 1, 0);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h10;
        req_wdata  = 32'h0000_1111;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check("rmw_in_merge", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        check("rmw_rst_ctrl", {27'd0, req_ready, resp_valid, resp_err, mem_we, mem_re}, 32'd0);
        check("rmw_rst_wdata", mem_wdata, 32'd0);
        check("rmw_rst_rdata", resp_rdata, 32'd0);
        check("rmw_rst_addr", {27'd0, mem_addr}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rmw_rst_mem", mem[4], 32'hAAAA_AAAA);
        #1 check("rmw_rel_ready", {31'd0, req_ready}, 32'd1);
        req_expect("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hAAAA_AAAA, 1'b0, 2, 0, 1);

        // Held request: three LWs back to back
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h08;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ready_mask[i] = req_ready;
            resp_mask[i]  = resp_valid;
            if (resp_valid) check("hs_rdata", resp_rdata, 32'hBEEF_80F0);
            if (i == 8) req_valid = 1'b0;
        end
        check("hs_ready_mask", {23'd0, ready_mask}, 32'h049);
        check("hs_resp_mask",  {23'd0, resp_mask},  32'h124);
        repeat (4) @(negedge clk);
        check("hs_no_extra", {31'd0, resp_valid}, 32'd0);

        check("we_re_exclusive", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the memory stage of the RISC-V pipeline and the word-addressed data memory. It accepts one load or store request at a time, checks alignment and funct3, and converts byte and halfword accesses into word accesses. Sub-word stores use a read-modify-write sequence. Loads return a sign- or zero-extended 32-bit result. It drives the data memory's write-enable, read-enable, word-address and write-data inputs, and consumes its combinational read data.

## Interface
- WIDTH, 32, data width; only 32 is supported.
- INDEX, 5, word-address width of the data memory (2**INDEX words).

- clk_in  input  1  clock; all state changes on the rising edge.
- rst_in  input  1  reset; asynchronous, active-high.
- req_valid_in  input  1  request present.
- req_ready_out  output  1  unit can accept a request this cycle.
- req_we_in  input  1  1 = store, 0 = load.
- req_funct3_in  input  3  RISC-V funct3:
  - loads: LB 000, LH 001, LW 010, LBU 100, LHU 101;
  - stores: SB 000, SH 001, SW 010.
- req_addr_in  input  WIDTH  byte address.
- req_wdata_in  input  WIDTH  store data; the low byte/halfword is used for SB/SH.
- resp_valid_out  output  1  one-cycle completion pulse.
- resp_rdata_out  output  WIDTH  extended load result; 0 for stores and errors.
- resp_err_out  output  1  request was misaligned or had an illegal funct3.
- mem_we_out  output  1  data-memory write enable.
- mem_re_out  output  1  data-memory read enable.
- mem_addr_out  output  INDEX  word address = req_addr_in[INDEX+1:2]; upper bits ignored.
- mem_wdata_out  output  WIDTH  word to write.
- mem_rdata_in  input  WIDTH  data-memory read word; combinational in the cycle mem_re_out is high.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP.
- IDLE:
  - req_ready_out=1.
  - On req_valid_in, capture we, funct3, addr and wdata.
  - Illegal funct3 → RESP with err.
    - Loads: 011, 110, 111.
    - Stores: any value above 010.
  - Misaligned (half with addr[0]≠0; word with addr[1:0]≠0) → RESP with err.
  - Otherwise → ACCESS.
- ACCESS, by request type:
  - Load: mem_re_out=1. At the edge, register the extracted lane of mem_rdata_in and → RESP.
    - Lane = addr[1:0] for bytes, addr[1] for halves.
    - LB/LH sign-extend; LBU/LHU zero-extend.
  - SW: mem_we_out=1, mem_wdata_out=wdata; the memory writes on the falling edge. → RESP.
  - SB/SH: mem_re_out=1. Capture mem_rdata_in into a merge register and → MERGE.
- MERGE (SB/SH only):
  - mem_we_out=1, same address.
  - mem_wdata_out = captured word with the addressed byte/half replaced by wdata[7:0]/wdata[15:0].
  - → RESP.
- RESP: resp_valid_out=1 for one cycle with the registered rdata and err, then → IDLE.
  - No response backpressure; the consumer must accept the pulse.
- Memory-side rules:
  - mem_we_out and mem_re_out are never both 1.
  - Both are 0 outside ACCESS/MERGE.
  - mem_addr_out and mem_wdata_out are driven only from registered state, so they are stable before the falling edge.
- Errored requests never touch memory.

## Timing
- Request accepted at rising edge N.
- Response: resp_valid_out is high in cycle:
  - N+1 for errors;
  - N+2 for loads and SW;
  - N+3 for SB/SH.
- Throughput is one request per latency + 1 cycles; req_ready_out is 0 outside IDLE.
- Reset (any time, including mid-RMW):
  - State goes to IDLE immediately.
  - All outputs go to 0, including req_ready_out while rst_in=1; it returns to 1 after release.
  - An aborted RMW issues no write, so memory is unchanged.
- req_valid_in while not ready is ignored; the requester holds it.
- Back-to-back: a request presented in the RESP cycle is not accepted; it is accepted the following cycle.

## Structure
- Package lsu_pkg:
  - state enum (IDLE, ACCESS, MERGE, RESP);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - function is_misaligned(funct3, addr[1:0]).
- Sub-module lsu_align (combinational):
  - load path: word + addr[1:0] + funct3 → extended result;
  - store path: old word + wdata + addr[1:0] + funct3 → merged word.
- lsu holds the FSM and the request/merge registers.

## Test plan
- SW 0x1234_5678 to addr 0x08, then LW 0x08:
  - mem_we_out pulses once at word 2;
  - load resp at N+2 returns 0x1234_5678, err=0.
- After the previous store, SB 0xAB to 0x09, then LW 0x08:
  - one read cycle, then one write cycle;
  - result 0x1234_AB78, store resp at N+3.
- Word 0x08 = 0x0000_80F0:
  - LB 0x08 → 0xFFFF_FFF0;
  - LBU 0x08 → 0x0000_00F0;
  - LH 0x08 → 0xFFFF_80F0;
  - LHU 0x08 → 0x0000_80F0.
- Error cases:
  - LW 0x0A and SH 0x03 → err=1 at N+1, no mem_we_out/mem_re_out activity;
  - funct3 011 load → err=1.
- Reset during RMW:
  - SH 0x1111 to 0x10 (word previously 0xAAAA_AAAA), assert rst_in in the MERGE cycle;
  - no write occurs, outputs 0, word stays 0xAAAA_AAAA;
  - next request after release is accepted normally.
- Handshake: hold req_valid_in high for 3 consecutive LW requests → exactly 3 responses at 3-cycle spacing; req_ready_out=0 in non-IDLE cycles.
